// File: rtl/fix_audio_ns_mc_if.sv
// Sample bus between the audio front-end and fix_audio_ns_mc.
// The front-end toggles req per sample; the datapath toggles ack per result.
interface fix_audio_ns_mc_if #(
  parameter int WID = 16,
  parameter int CHW = 2
) ();
  logic           req;
  logic [CHW-1:0] rx_ch;
  logic [WID-1:0] rx_data;
  logic           ack;
  logic [CHW-1:0] tx_ch;
  logic [WID-1:0] tx_data;
  logic           overflow;

  modport master (
    output req, rx_ch, rx_data,
    input  ack, tx_ch, tx_data, overflow
  );

  modport slave (
    input  req, rx_ch, rx_data,
    output ack, tx_ch, tx_data, overflow
  );
endinterface

// File: rtl/fix_audio_ns_mc.sv
// Multi-channel fixed-point noise suppressor: gain -> biquad HPF -> Kalman -> gain,
// all channels time-multiplexed through one saturating MAC, fixed 10-cycle latency.
module fix_audio_ns_mc #(
  parameter int WID  = 16,
  parameter int FRAC = 10,
  parameter int CH   = 4,
  parameter int CHW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [8*WID+3:0]   conf,
  input  logic               clr_state,
  output logic               missed,
  fix_audio_ns_mc_if.slave   bus
);

  localparam int PW      = 2*WID + 2;
  localparam int BYP_IN  = 3;
  localparam int BYP_HPF = 2;
  localparam int BYP_KAL = 1;
  localparam int BYP_VOL = 0;
  localparam logic signed [PW-1:0] MAXV = {{(PW-WID+1){1'b0}}, {(WID-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-WID+1){1'b1}}, {(WID-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_GIN, S_BQ0, S_BQ1, S_BQ2, S_BQ3, S_BQ4, S_KAL, S_GOUT, S_DONE
  } state_t;

  typedef struct packed {
    logic signed [WID-1:0] b0, b1, b2, a1, a2, k, vol, in_vol;
    logic [3:0]            byp;
  } conf_t;

  state_t state, state_nx;
  conf_t  cf_r;

  logic [1:0]            req_d;
  logic                  req_x;
  logic                  ch_valid, ch_ok;
  logic [CHW-1:0]        ch_r;
  logic signed [WID-1:0] x_r, d_r, acc_r;
  logic                  ovf_r;

  logic signed [WID-1:0] x1_m [CH];
  logic signed [WID-1:0] x2_m [CH];
  logic signed [WID-1:0] y1_m [CH];
  logic signed [WID-1:0] y2_m [CH];
  logic signed [WID-1:0] es_m [CH];
  logic signed [WID-1:0] x1_rd, x2_rd, y1_rd, y2_rd, es_rd;

  logic signed [WID-1:0]   mac_a, mac_b, mac_c, mac_res, diff_sat;
  logic                    mac_neg, mac_ovf, diff_ovf, stage_on, step_ovf;
  logic signed [2*WID-1:0] prod;
  logic signed [PW-1:0]    prod_x, term, sum, diff_w;

  function automatic logic [WID:0] sat(input logic signed [PW-1:0] v);
    if (v > MAXV)      return {1'b1, MAXV[WID-1:0]};
    else if (v < MINV) return {1'b1, MINV[WID-1:0]};
    else               return {1'b0, v[WID-1:0]};
  endfunction

  assign req_x = req_d[0] ^ req_d[1];

  if (CH >= (1 << CHW)) begin : g_ch_full
    assign ch_valid = 1'b1;
  end else begin : g_ch_part
    assign ch_valid = (int'(bus.rx_ch) < CH);
  end

  // An invalid channel never touches the history arrays; it reads zeros instead.
  assign x1_rd = ch_ok ? x1_m[ch_r] : '0;
  assign x2_rd = ch_ok ? x2_m[ch_r] : '0;
  assign y1_rd = ch_ok ? y1_m[ch_r] : '0;
  assign y2_rd = ch_ok ? y2_m[ch_r] : '0;
  assign es_rd = ch_ok ? es_m[ch_r] : '0;

  // Shared MAC: sum is kept wide so the clamp sees the true value, then saturates to WID.
  always_comb begin
    prod   = mac_a * mac_b;
    prod_x = {{2{prod[2*WID-1]}}, prod};
    if (mac_neg) prod_x = -prod_x;
    term   = prod_x >>> FRAC;
    sum    = term + $signed({{(PW-WID){mac_c[WID-1]}}, mac_c});
    {mac_ovf, mac_res} = sat(sum);
    diff_w = $signed({{(PW-WID){d_r[WID-1]}}, d_r}) - $signed({{(PW-WID){es_rd[WID-1]}}, es_rd});
    {diff_ovf, diff_sat} = sat(diff_w);
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    mac_a    = '0;
    mac_b    = '0;
    mac_c    = '0;
    mac_neg  = 1'b0;
    stage_on = 1'b0;
    step_ovf = mac_ovf;
    unique case (state)
      S_IDLE: if (req_x) state_nx = S_GIN;
      S_GIN: begin
        mac_a = cf_r.in_vol; mac_b = x_r;
        stage_on = !cf_r.byp[BYP_IN];
        state_nx = S_BQ0;
      end
      S_BQ0: begin
        mac_a = cf_r.b0; mac_b = d_r;
        stage_on = !cf_r.byp[BYP_HPF];
        state_nx = S_BQ1;
      end
      S_BQ1: begin
        mac_a = cf_r.b1; mac_b = x1_rd; mac_c = acc_r;
        stage_on = !cf_r.byp[BYP_HPF];
        state_nx = S_BQ2;
      end
      S_BQ2: begin
        mac_a = cf_r.b2; mac_b = x2_rd; mac_c = acc_r;
        stage_on = !cf_r.byp[BYP_HPF];
        state_nx = S_BQ3;
      end
      S_BQ3: begin
        mac_a = cf_r.a1; mac_b = y1_rd; mac_c = acc_r; mac_neg = 1'b1;
        stage_on = !cf_r.byp[BYP_HPF];
        state_nx = S_BQ4;
      end
      S_BQ4: begin
        mac_a = cf_r.a2; mac_b = y2_rd; mac_c = acc_r; mac_neg = 1'b1;
        stage_on = !cf_r.byp[BYP_HPF];
        state_nx = S_KAL;
      end
      S_KAL: begin
        mac_a = cf_r.k; mac_b = diff_sat; mac_c = es_rd;
        stage_on = !cf_r.byp[BYP_KAL];
        step_ovf = mac_ovf | diff_ovf;
        state_nx = S_GOUT;
      end
      S_GOUT: begin
        mac_a = cf_r.vol; mac_b = d_r;
        stage_on = !cf_r.byp[BYP_VOL];
        state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_d        <= {bus.req, bus.req};
      x_r          <= '0;
      ch_r         <= '0;
      ch_ok        <= 1'b0;
      cf_r         <= '0;
      d_r          <= '0;
      acc_r        <= '0;
      ovf_r        <= 1'b0;
      missed       <= 1'b0;
      bus.ack      <= 1'b0;
      bus.tx_ch    <= '0;
      bus.tx_data  <= '0;
      bus.overflow <= 1'b0;
    end else if (enable) begin
      state <= state_nx;
      req_d <= {req_d[0], bus.req};
      if (clr_state)                     missed <= 1'b0;
      else if (req_x && state != S_IDLE) missed <= 1'b1;

      if (state == S_IDLE && req_x) begin
        x_r   <= bus.rx_data;
        ch_r  <= bus.rx_ch;
        ch_ok <= ch_valid;
        cf_r  <= conf;
        ovf_r <= 1'b0;
      end
      if (stage_on) ovf_r <= ovf_r | step_ovf;

      case (state)
        S_GIN:                      d_r   <= stage_on ? mac_res : x_r;
        S_BQ0, S_BQ1, S_BQ2, S_BQ3: acc_r <= mac_res;
        S_BQ4, S_KAL, S_GOUT:       if (stage_on) d_r <= mac_res;
        S_DONE: begin
          bus.ack      <= ~bus.ack;
          bus.tx_ch    <= ch_r;
          bus.tx_data  <= ch_ok ? d_r : '0;
          bus.overflow <= ch_ok ? ovf_r : 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the history arrays are reset explicitly because a cleared channel must restart from zero.
  always_ff @(posedge clk) begin
    if (rst || (enable && clr_state)) begin
      for (int i = 0; i < CH; i++) begin
        x1_m[i] <= '0;
        x2_m[i] <= '0;
        y1_m[i] <= '0;
        y2_m[i] <= '0;
        es_m[i] <= '0;
      end
    end else if (enable && ch_ok) begin
      if (state == S_BQ4 && !cf_r.byp[BYP_HPF]) begin
        x2_m[ch_r] <= x1_m[ch_r];
        x1_m[ch_r] <= d_r;
        y2_m[ch_r] <= y1_m[ch_r];
        y1_m[ch_r] <= mac_res;
      end
      if (state == S_KAL && !cf_r.byp[BYP_KAL]) es_m[ch_r] <= mac_res;
    end
  end

endmodule

// File: tb/tb_fix_audio_ns_mc.sv
// Directed bench for fix_audio_ns_mc: latency, saturation, channel isolation,
// Kalman smoothing, missed-request handling, clear and mid-sample reset.
module tb_fix_audio_ns_mc;
  localparam int WID  = 16;
  localparam int FRAC = 10;
  localparam int CH   = 4;
  localparam int CHW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             clr_state;
  logic             missed;
  logic [8*WID+3:0] conf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fix_audio_ns_mc_if #(.WID(WID), .CHW(CHW)) bus ();

  fix_audio_ns_mc #(.WID(WID), .FRAC(FRAC), .CH(CH), .CHW(CHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .conf      (conf),
    .clr_state (clr_state),
    .missed    (missed),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8*WID+3:0] mk_conf(input int b0, b1, b2, a1, a2, k, vol, in_vol,
                                               input logic [3:0] byp);
    return {WID'(b0), WID'(b1), WID'(b2), WID'(a1), WID'(a2), WID'(k), WID'(vol), WID'(in_vol), byp};
  endfunction

  // Toggle req at a negedge; lat counts posedges from E (the first one) to the ack toggle.
  task automatic sample(input int ch, input int data, output int lat);
    logic a0;
    @(negedge clk);
    bus.rx_ch   = CHW'(ch);
    bus.rx_data = WID'(data);
    a0          = bus.ack;
    bus.req     = ~bus.req;
    lat         = -1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack !== a0) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input int ch, input int data,
                     input int exp_data, input int exp_ovf);
    int lat;
    sample(ch, data, lat);
    check({tag, "_lat"},  lat, 10);
    check({tag, "_data"}, $signed(bus.tx_data), exp_data);
    check({tag, "_ch"},   {30'd0, bus.tx_ch}, ch);
    check({tag, "_ovf"},  {31'd0, bus.overflow}, exp_ovf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic prev;

    rst         = 1'b1;
    enable      = 1'b1;
    clr_state   = 1'b0;
    conf        = '0;
    bus.req     = 1'b0;
    bus.rx_ch   = '0;
    bus.rx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack",    {31'd0, bus.ack}, 0);
    check("rst_data",   $signed(bus.tx_data), 0);
    check("rst_ch",     {30'd0, bus.tx_ch}, 0);
    check("rst_ovf",    {31'd0, bus.overflow}, 0);
    check("rst_missed", {31'd0, missed}, 0);

    // All stages bypassed: data passes straight through.
    conf = mk_conf(0, 0, 0, 0, 0, 0, 0, 0, 4'b1111);
    run("t1", 2, 'h1234, 'h1234, 0);

    // Input gain x2 saturates both ways.
    conf = mk_conf(0, 0, 0, 0, 0, 0, 0, 2048, 4'b0111);
    run("t2_pos", 1, 20000, 32767, 1);
    run("t2_neg", 1, -20000, -32768, 1);

    // HPF only, b0=b1=0.5: channel histories must stay separate.
    conf = mk_conf(512, 512, 0, 0, 0, 0, 0, 0, 4'b1011);
    run("t3_a", 0, 1000, 500, 0);
    run("t3_b", 1, 4000, 2000, 0);
    run("t3_c", 0, 3000, 2000, 0);

    // Kalman only, k=0.5.
    conf = mk_conf(0, 0, 0, 0, 0, 512, 0, 0, 4'b1101);
    run("t4_a", 0, 1024, 512, 0);
    run("t4_b", 0, 1024, 768, 0);
    run("t4_c", 3, 1024, 512, 0);

    // Second req edge three cycles into a sample is dropped and flagged.
    conf = mk_conf(0, 0, 0, 0, 0, 0, 0, 0, 4'b1111);
    @(negedge clk);
    bus.rx_ch   = 2'd1;
    bus.rx_data = 16'd7;
    prev        = bus.ack;
    bus.req     = ~bus.req;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.req = ~bus.req;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack !== prev) begin
        n++;
        prev = bus.ack;
      end
    end
    check("t5_acks",   n, 1);
    check("t5_data",   $signed(bus.tx_data), 7);
    check("t5_missed", {31'd0, missed}, 1);
    @(negedge clk);
    clr_state = 1'b1;
    @(negedge clk);
    clr_state = 1'b0;
    check("t5_clr_missed", {31'd0, missed}, 0);
    conf = mk_conf(0, 0, 0, 0, 0, 512, 0, 0, 4'b1101);
    run("t5_kal", 0, 1024, 512, 0);

    // Reset in the middle of a sample: no ack, outputs zero, history cleared.
    conf = mk_conf(512, 512, 0, 0, 0, 0, 0, 0, 4'b1011);
    run("t6_pre", 0, 1000, 500, 0);
    @(negedge clk);
    bus.rx_ch   = 2'd0;
    bus.rx_data = 16'd1000;
    bus.req     = ~bus.req;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t6_ack",    {31'd0, bus.ack}, 0);
    check("t6_data",   $signed(bus.tx_data), 0);
    check("t6_ch",     {30'd0, bus.tx_ch}, 0);
    check("t6_ovf",    {31'd0, bus.overflow}, 0);
    check("t6_missed", {31'd0, missed}, 0);
    run("t6_post", 0, 1000, 500, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
